// File: rtl/player_input_conditioner.sv
// rtl/player_input_conditioner.sv - debounced one-hot colour and START strobes for the controller
module player_input_conditioner #(
  parameter int CLK_FREQ    = 200,
  parameter int DEBOUNCE_US = 10,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       start_raw,
  input  logic       accept_en,
  output logic [3:0] player_input,
  output logic       player_valid,
  output logic       multi_err,
  output logic       start_pulse
);

  localparam int DB_PROD   = CLK_FREQ * DEBOUNCE_US;
  localparam int DB_CYCLES = (DB_PROD < 1) ? 1 : DB_PROD;
  localparam int CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LAST      = DB_CYCLES - 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
  localparam logic [CNT_W:0]   LAST_EXT = (CNT_W + 1)'(LAST);
  localparam logic [CNT_W:0]   ONE_EXT  = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Released level of the raw pins; the synchronisers come out of reset here
  localparam logic [4:0] REL_LEVEL = ACTIVE_LOW ? 5'b11111 : 5'b00000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRESS_DB = 3'd1;
  localparam logic [2:0] ST_EVAL     = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_REL_DB   = 3'd4;

  logic [4:0]       sync_q1;
  logic [4:0]       sync_q2;
  logic [4:0]       pressed;
  logic [3:0]       p;
  logic             start_p;

  logic [2:0]       state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_plus1;
  logic             win_done;
  logic             cand_onehot;
  logic             eval_accept;

  logic             start_level;
  logic [CNT_W-1:0] start_cnt;

  // Two-flop synchroniser for the four colour buttons and START together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= REL_LEVEL;
      sync_q2 <= REL_LEVEL;
    end else begin
      sync_q1 <= {start_raw, btn_raw};
      sync_q2 <= sync_q1;
    end
  end

  // 1 = pressed, regardless of board polarity
  assign pressed = ACTIVE_LOW ? ~sync_q2 : sync_q2;
  assign p       = pressed[3:0];
  assign start_p = pressed[4];

  // The window closes on the cycle the incremented count reaches DB_CYCLES-1,
  // so the steady level is seen on exactly DB_CYCLES edges including entry.
  assign cnt_plus1 = {1'b0, cnt} + ONE_EXT;
  assign win_done  = (cnt_plus1 >= LAST_EXT);

  assign cand_onehot = (cand != 4'b0000) && ((cand & (cand - 4'b0001)) == 4'b0000);
  assign eval_accept = (state == ST_EVAL) && cand_onehot && accept_en;

  // Colour press/release state machine sharing one debounce counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HOLD;
      cand  <= 4'b0000;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (p != 4'b0000) begin
            cand  <= p;
            cnt   <= '0;
            state <= ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (p == 4'b0000) begin
            state <= ST_IDLE;
          end else if (p != cand) begin
            cand <= p;
            cnt  <= '0;
          end else begin
            cnt <= cnt_plus1[CNT_W-1:0];
            if (win_done) begin
              state <= ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (p == 4'b0000) begin
            cnt   <= '0;
            state <= ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (p != 4'b0000) begin
            state <= ST_HOLD;
          end else begin
            cnt <= cnt_plus1[CNT_W-1:0];
            if (win_done) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  // Registered colour strobes; only the EVAL cycle can raise them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_valid <= 1'b0;
      player_input <= 4'b0000;
      multi_err    <= 1'b0;
    end else begin
      player_valid <= eval_accept;
      player_input <= eval_accept ? cand : 4'b0000;
      multi_err    <= (state == ST_EVAL) && !cand_onehot;
    end
  end

  // START level debouncer; a change must persist DB_CYCLES edges to be taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_level <= 1'b0;
      start_cnt   <= '0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (start_p != start_level) begin
        if (start_cnt == CNT_LAST) begin
          start_level <= start_p;
          start_cnt   <= '0;
          start_pulse <= start_p;
        end else begin
          start_cnt <= start_cnt + CNT_ONE;
        end
      end else begin
        start_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_player_input_conditioner.sv
// tb/tb_player_input_conditioner.sv - scoreboard bench for player_input_conditioner
module tb_player_input_conditioner;

  localparam int DB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic       start_raw;
  logic       accept_en;
  logic [3:0] player_input;
  logic       player_valid;
  logic       multi_err;
  logic       start_pulse;

  player_input_conditioner #(
    .CLK_FREQ    (1),
    .DEBOUNCE_US (4),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .start_raw    (start_raw),
    .accept_en    (accept_en),
    .player_input (player_input),
    .player_valid (player_valid),
    .multi_err    (multi_err),
    .start_pulse  (start_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       err;
    logic [3:0] code;
  } col_ev_t;

  col_ev_t cq[$];
  int      sq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int n_valid = 0;
  int n_multi = 0;
  int n_start = 0;
  logic [3:0] last_code = 4'b0000;
  int last_valid_cyc = 0;
  int t_mark = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: delays the pressed vector by the two sync stages and
  // judges presses by run lengths of identical samples.
  logic [3:0] m_d1, m_d2;
  logic       m_s1, m_s2;
  bit         m_armed;
  int         m_zr, m_run;
  logic [3:0] m_last;
  bit         m_pend;
  logic [3:0] m_cand;
  logic       m_dl;
  int         m_sc;

  always @(posedge clk) begin
    logic [3:0] mp;
    logic       ms;
    cyc++;
    if (!rst_n) begin
      m_d1 = 4'b0; m_d2 = 4'b0; m_s1 = 1'b0; m_s2 = 1'b0;
      m_armed = 1'b0; m_zr = 0; m_run = 0; m_last = 4'b0;
      m_pend = 1'b0; m_cand = 4'b0; m_dl = 1'b0; m_sc = 0;
      cq.delete();
      sq.delete();
    end else begin
      mp = m_d2; m_d2 = m_d1; m_d1 = ~btn_raw;
      ms = m_s2; m_s2 = m_s1; m_s1 = ~start_raw;
      if (m_pend) begin
        m_pend  = 1'b0;
        m_armed = 1'b0;
        m_zr    = 0;
        if ($countones(m_cand) > 1) cq.push_back('{cyc, 1'b1, 4'b0000});
        else if (accept_en) cq.push_back('{cyc, 1'b0, m_cand});
      end else if (!m_armed) begin
        if (mp == 4'b0) begin
          m_zr++;
          if (m_zr == DB) begin m_armed = 1'b1; m_run = 0; end
        end else begin
          m_zr = 0;
        end
      end else begin
        if (mp == 4'b0) m_run = 0;
        else if (m_run > 0 && mp == m_last) m_run++;
        else begin m_run = 1; m_last = mp; end
        if (m_run == DB) begin m_pend = 1'b1; m_cand = m_last; end
      end
      if (ms != m_dl) begin
        m_sc++;
        if (m_sc == DB) begin
          m_dl = ms; m_sc = 0;
          if (ms) sq.push_back(cyc);
        end
      end else begin
        m_sc = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes
  always @(negedge clk) begin
    col_ev_t e;
    int      sc;
    if (!rst_n) begin
      chk("reset_outputs", {25'b0, player_input, player_valid, multi_err, start_pulse}, 32'd0);
    end else begin
      if (player_valid || multi_err) begin
        if (player_valid) begin n_valid++; last_code = player_input; last_valid_cyc = cyc; end
        if (multi_err) n_multi++;
        if (cq.size() == 0) begin
          chk("colour_unexpected", {30'b0, player_valid, multi_err}, 32'd0);
        end else begin
          e = cq.pop_front();
          chk("colour_cycle", cyc, e.cyc);
          chk("colour_kind", {30'b0, player_valid, multi_err}, e.err ? 32'd1 : 32'd2);
          chk("colour_code", {28'b0, player_input}, {28'b0, e.err ? 4'b0000 : e.code});
        end
      end else begin
        chk("idle_input", {28'b0, player_input}, 32'd0);
        if (cq.size() > 0 && cq[0].cyc < cyc) begin
          e = cq.pop_front();
          chk("colour_missed", 32'd0, e.cyc);
        end
      end
      if (start_pulse) begin
        n_start++;
        if (sq.size() == 0) begin
          chk("start_unexpected", 32'd1, 32'd0);
        end else begin
          sc = sq.pop_front();
          chk("start_cycle", cyc, sc);
        end
      end else if (sq.size() > 0 && sq[0] < cyc) begin
        sc = sq.pop_front();
        chk("start_missed", 32'd0, sc);
      end
    end
  end

  task automatic drive(input logic [3:0] b, input logic s, input logic a, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      btn_raw = b; start_raw = s; accept_en = a;
      if (i == 0) t_mark = cyc;
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", {28'b0, player_input, player_valid, multi_err, start_pulse, 1'b0}, 32'd0);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int v0, m0, s0, mark, len;
    logic [3:0] pat, prev;
    logic s, a;
    rst_n = 1'b0; btn_raw = 4'b1111; start_raw = 1'b1; accept_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    drive(4'b1111, 1'b1, 1'b1, 12);

    // 1: single press, latency and no repeat while held
    v0 = n_valid; m0 = n_multi;
    drive(4'b1101, 1'b1, 1'b1, 20); mark = t_mark;
    drive(4'b1111, 1'b1, 1'b1, 10);
    chk("t1_count", n_valid - v0, 32'd1);
    chk("t1_code", {28'b0, last_code}, 32'b0010);
    chk("t1_latency", last_valid_cyc - mark, 32'd7);
    chk("t1_multi", n_multi - m0, 32'd0);

    // 2: bounce shorter than the window
    v0 = n_valid; m0 = n_multi;
    for (int k = 0; k < 5; k++) drive((k % 2 == 0) ? 4'b1110 : 4'b1111, 1'b1, 1'b1, 2);
    drive(4'b1111, 1'b1, 1'b1, 12);
    chk("t2_valid", n_valid - v0, 32'd0);
    chk("t2_multi", n_multi - m0, 32'd0);

    // 3: chord
    v0 = n_valid; m0 = n_multi;
    drive(4'b1100, 1'b1, 1'b1, 15);
    drive(4'b1111, 1'b1, 1'b1, 10);
    chk("t3_multi", n_multi - m0, 32'd1);
    chk("t3_valid", n_valid - v0, 32'd0);

    // 4: accept_en gating
    v0 = n_valid;
    drive(4'b1011, 1'b1, 1'b0, 10);
    drive(4'b1111, 1'b1, 1'b0, 10);
    drive(4'b0111, 1'b1, 1'b1, 10);
    drive(4'b1111, 1'b1, 1'b1, 10);
    chk("t4_count", n_valid - v0, 32'd1);
    chk("t4_code", {28'b0, last_code}, 32'b1000);

    // 5: START press and short glitch
    s0 = n_start;
    drive(4'b1111, 1'b0, 1'b1, 10);
    drive(4'b1111, 1'b1, 1'b1, 10);
    chk("t5_press", n_start - s0, 32'd1);
    s0 = n_start;
    drive(4'b1111, 1'b0, 1'b1, 2);
    drive(4'b1111, 1'b1, 1'b1, 10);
    chk("t5_glitch", n_start - s0, 32'd0);

    // 6: reset while a button is held
    drive(4'b1110, 1'b1, 1'b1, 10);
    pulse_reset(2);
    v0 = n_valid;
    drive(4'b1110, 1'b1, 1'b1, 15);
    chk("t6_held", n_valid - v0, 32'd0);
    drive(4'b1111, 1'b1, 1'b1, 10);
    drive(4'b1110, 1'b1, 1'b1, 10);
    drive(4'b1111, 1'b1, 1'b1, 10);
    chk("t6_count", n_valid - v0, 32'd1);
    chk("t6_code", {28'b0, last_code}, 32'b0001);

    // Random segments against the model
    prev = 4'b0000;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: pat = 4'b0000;
        4, 5, 6:    pat = 4'b0001 << $urandom_range(0, 3);
        7, 8:       pat = 4'($urandom_range(0, 15));
        default:    pat = prev ^ (4'b0001 << $urandom_range(0, 3));
      endcase
      prev = pat;
      s   = ($urandom_range(0, 2) == 0);
      a   = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 59) == 0) pulse_reset(1);
      drive(~pat, ~s, a, len);
    end
    drive(4'b1111, 1'b1, 1'b1, 20);

    chk("colour_queue_empty", cq.size(), 32'd0);
    chk("start_queue_empty", sq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
